// File: rtl/ycbcr_pkg.sv
// Shared widths, the packed FIFO word layout and small helpers for the 4:2:2 packer.
package ycbcr_pkg;
   localparam int PIX_W  = 8;
   localparam int WORD_W = 16;

   typedef struct packed {
      logic             eof;
      logic             eol;
      logic             sof;
      logic [PIX_W-1:0] c;
      logic [PIX_W-1:0] y;
   } word_t;

   // Counter width that never collapses to zero bits for tiny dimensions.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [PIX_W-1:0] avg_round(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
      logic [PIX_W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
      return s[PIX_W:1];
   endfunction
endpackage

// File: rtl/ycbcr422_packer_pix_fifo4.sv
// Four-entry register FIFO: pushes two words at once, pops one; the caller
// guarantees at least two free slots before asserting push2.
module pix_fifo4
   import ycbcr_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push2,
   input  word_t      din0,
   input  word_t      din1,
   input  logic       pop,
   output word_t      dout,
   output logic       empty,
   output logic [2:0] count
);
   word_t      mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic       do_pop;

   assign empty  = (count == 3'd0);
   assign do_pop = pop && !empty;
   assign dout   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push2) begin
         mem[wr_ptr]        <= din0;
         mem[wr_ptr + 2'd1] <= din1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push2)  wr_ptr <= wr_ptr + 2'd2;
         if (do_pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + (push2 ? 3'd2 : 3'd0) - (do_pop ? 3'd1 : 3'd0);
      end
   end
endmodule

// File: rtl/ycbcr422_packer.sv
// Packs 8-bit Y/Cb/Cr pixels into 16-bit 4:2:2 {C,Y} words with frame/line tags.
// Both ports: a beat transfers on the cycle where valid && ready; valid never waits on ready.
module ycbcr422_packer
   import ycbcr_pkg::*;
#(
   parameter int LINE_W  = 640,
   parameter int FRAME_H = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sof,
   input  logic [PIX_W-1:0]  in_y,
   input  logic [PIX_W-1:0]  in_cb,
   input  logic [PIX_W-1:0]  in_cr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_sof,
   output logic              out_eol,
   output logic              out_eof,
   output logic              err_sync,
   output logic              dbg_state
);
   localparam int COL_W = clog2_min1(LINE_W);
   localparam int LIN_W = clog2_min1(FRAME_H);
   localparam logic [0:0] ST_EVEN = 1'b0;
   localparam logic [0:0] ST_ODD  = 1'b1;

   generate
      if (LINE_W % 2 != 0) begin : g_line_w_odd
         $error("ycbcr422_packer: LINE_W must be even");
      end
   endgenerate

   logic [0:0]       state;
   logic [COL_W-1:0] col;
   logic [LIN_W-1:0] line;
   logic [PIX_W-1:0] y0, cb0, cr0;
   logic             sof0;
   logic             accept, push2, at_origin, col_last, line_last;
   logic [2:0]       fifo_count;
   logic             fifo_empty;
   word_t            fifo_dout, head, w_cb, w_cr;

   assign at_origin = (col == '0) && (line == '0);
   assign col_last  = (col == COL_W'(LINE_W - 1));
   assign line_last = (line == LIN_W'(FRAME_H - 1));

   // In ODD the pair pushes two words, so a same-cycle pop is not counted as space.
   assign in_ready = rst_n && ((state == ST_EVEN) || (fifo_count <= 3'd2));
   assign accept   = in_valid && in_ready;
   assign push2    = accept && (state == ST_ODD) && !in_sof;

   always_comb begin
      w_cb     = '0;
      w_cb.sof = sof0;
      w_cb.c   = avg_round(cb0, in_cb);
      w_cb.y   = y0;
      w_cr     = '0;
      w_cr.eol = col_last;
      w_cr.eof = col_last && line_last;
      w_cr.c   = avg_round(cr0, in_cr);
      w_cr.y   = in_y;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_EVEN;
         col      <= '0;
         line     <= '0;
         y0       <= '0;
         cb0      <= '0;
         cr0      <= '0;
         sof0     <= 1'b0;
         err_sync <= 1'b0;
      end else if (accept) begin
         // A frame marker restarts pairing: the marked pixel is always the even one.
         if (in_sof || state == ST_EVEN) begin
            y0    <= in_y;
            cb0   <= in_cb;
            cr0   <= in_cr;
            sof0  <= in_sof || at_origin;
            state <= ST_ODD;
         end else begin
            state <= ST_EVEN;
         end
         if (in_sof) begin
            if (state == ST_ODD || !at_origin) err_sync <= 1'b1;
            col  <= COL_W'(1);
            line <= '0;
         end else if (col_last) begin
            col  <= '0;
            line <= line_last ? '0 : line + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   pix_fifo4 u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push2 (push2),
      .din0  (w_cb),
      .din1  (w_cr),
      .pop   (out_ready),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Unwritten FIFO slots are never exposed, keeping all outputs at 0 when idle.
   assign head      = fifo_empty ? '0 : fifo_dout;
   assign out_valid = !fifo_empty;
   assign out_data  = {head.c, head.y};
   assign out_sof   = head.sof;
   assign out_eol   = head.eol;
   assign out_eof   = head.eof;
   assign dbg_state = state[0];
endmodule

// File: tb/tb_ycbcr422_packer.sv
// Scoreboarded bench for ycbcr422_packer on a 4x2 frame: directed cases plus random valid/ready.
module tb_ycbcr422_packer;
  localparam int LW   = 4;
  localparam int FH   = 2;
  localparam int NPIX = LW * FH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_sof = 1'b0;
  logic [7:0]  in_y = '0, in_cb = '0, in_cr = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sof, out_eol, out_eof, err_sync, dbg_state;

  always #5 clk = ~clk;

  ycbcr422_packer #(.LINE_W(LW), .FRAME_H(FH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .err_sync(err_sync), .dbg_state(dbg_state)
  );

  logic [18:0] exp_q[$];
  logic [18:0] log_q[$];
  int          n_vec = 0, n_err = 0;
  int          pos = 0;
  logic        exp_err = 1'b0;
  logic [7:0]  h_y, h_cb, h_cr;
  logic        h_sof;
  int          rdy_mode = 0;
  int          stall_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: frame position as a pixel index; words emitted per completed pair.
  task automatic model_accept(input logic [7:0] y, cb, cr, input logic sof);
    int col, line, cba, cra;
    logic eol, eof;
    if (sof) begin
      if (pos != 0) exp_err = 1'b1;
      pos = 0;
    end
    col  = pos % LW;
    line = pos / LW;
    if (pos % 2 == 0) begin
      h_y = y; h_cb = cb; h_cr = cr; h_sof = (pos == 0);
    end else begin
      cba = (int'(h_cb) + int'(cb) + 1) / 2;
      cra = (int'(h_cr) + int'(cr) + 1) / 2;
      eol = (col == LW - 1);
      eof = eol && (line == FH - 1);
      exp_q.push_back({1'b0, 1'b0, h_sof, 8'(cba), h_y});
      exp_q.push_back({eof, eol, 1'b0, 8'(cra), y});
    end
    pos = (pos + 1) % NPIX;
  endtask

  task automatic send_pix(input logic [7:0] y, cb, cr, input logic sof);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_y = y; in_cb = cb; in_cr = cr; in_sof = sof;
    #2;
    while (!in_ready) begin
      waited++;
      if (waited > 100) begin
        n_vec++; n_err++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", waited);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #2;
    end
    model_accept(y, cb, cr, sof);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_rand(input int n, input logic first_sof);
    for (int i = 0; i < n; i++)
      send_pix(8'($urandom), 8'($urandom), 8'($urandom), first_sof && (i == 0));
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 200) begin
      @(negedge clk); #3; w++;
    end
    chk("drain_done", 32'(w < 200), 32'd1);
  endtask

  // Downstream ready generator: forced stalls take priority over the mode.
  always @(negedge clk) begin
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (rdy_mode == 1) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every accepted word, checks hold during stalls.
  logic        stalled_prev = 1'b0;
  logic [18:0] prev_word = '0;
  always @(negedge clk) begin
    logic [18:0] act;
    #2;
    act = {out_eof, out_eol, out_sof, out_data};
    if (rst_n && out_valid) begin
      if (stalled_prev) chk("stall_hold", 32'(act), 32'(prev_word));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", act);
        end else begin
          chk("word", 32'(act), 32'(exp_q.pop_front()));
        end
        log_q.push_back(act);
      end
      stalled_prev = !out_ready;
      prev_word    = act;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_err_sync", 32'(err_sync), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Directed pair with latency check, then finish the frame
    log_q.delete();
    send_pix(8'd10, 8'd100, 8'd50, 1'b1);
    send_pix(8'd20, 8'd101, 8'd60, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    #2;
    chk("pair_latency", 32'(out_valid), 1);
    drain();
    chk("pair_count", 32'(log_q.size()), 2);
    if (log_q.size() >= 2) begin
      chk("pair_word0", 32'(log_q[0]), 32'h1650A);
      chk("pair_word1", 32'(log_q[1]), 32'h03714);
    end
    send_rand(NPIX - 2, 1'b0);
    idle();
    drain();

    // Full-frame ramp: eol on words 4 and 8, eof only on word 8
    log_q.delete();
    for (int i = 0; i < NPIX; i++)
      send_pix(8'(i * 3 + 1), 8'(i * 17), 8'(255 - i * 9), i == 0);
    idle();
    drain();
    chk("frame_count", 32'(log_q.size()), 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      chk("frame_eol", 32'(log_q[k][17]), 32'((k == 3) || (k == 7)));
      chk("frame_eof", 32'(log_q[k][18]), 32'(k == 7));
      chk("frame_sof", 32'(log_q[k][16]), 32'(k == 0));
    end

    // Backpressure: FIFO fills, ODD pixel held off, no loss or duplication
    log_q.delete();
    stall_left = 12;
    send_rand(5, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b0;
    #2;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_state_odd", 32'(dbg_state), 1);
    chk("full_out_valid", 32'(out_valid), 1);
    send_rand(NPIX - 5, 1'b0);
    idle();
    drain();
    chk("bp_count", 32'(log_q.size()), 8);
    chk("no_err_yet", 32'(err_sync), 0);

    // Sync errors: marker on 3rd pixel of a line, then marker while a pixel is held
    send_rand(2, 1'b1);
    send_pix(8'h33, 8'h44, 8'h55, 1'b1);
    send_pix(8'h66, 8'h77, 8'h88, 1'b1);
    send_rand(NPIX - 1, 1'b0);
    idle();
    drain();
    @(negedge clk); #2;
    chk("err_sync_set", 32'(err_sync), 1);
    chk("err_sync_model", 32'(err_sync), 32'(exp_err));

    // Reset mid-stream with words stuck in the FIFO
    stall_left = 20;
    send_rand(3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    exp_q.delete(); pos = 0; exp_err = 1'b0; stall_left = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_err_sync", 32'(err_sync), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    send_rand(NPIX, 1'b1);
    idle();
    drain();
    chk("after_rst_count", 32'(log_q.size()), 8);
    chk("after_rst_err", 32'(err_sync), 0);

    // Random valid/ready over several frames
    rdy_mode = 1;
    for (int f = 0; f < 10; f++) begin
      for (int p = 0; p < NPIX; p++) begin
        if ($urandom_range(0, 1) == 1) idle();
        send_pix(8'($urandom), 8'($urandom), 8'($urandom), p == 0);
      end
    end
    idle();
    rdy_mode = 0;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_err_sync", 32'(err_sync), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
